// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg: shared types, funct3 codes and size helpers for the LSU     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes; the unsigned forms share the size of their signed twin.
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = 4'd1;
            F3_H, F3_HU: size_of = 4'd2;
            F3_W, F3_WU: size_of = 4'd4;
            default:     size_of = 4'd8;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [63:0] addr, input logic [2:0] funct3);
        logic [3:0] m;
        m = size_of(funct3) - 4'd1;
        is_misaligned = ((addr & 64'(m)) != 64'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_align: byte-lane mask, store shift and load extract/extend       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [7:0]  w_base;
    logic [63:0] w_rsh;

    always_comb begin
        w_base = 8'h00;
        case (funct3[1:0])
            2'd0:    w_base = 8'h01;
            2'd1:    w_base = 8'h03;
            2'd2:    w_base = 8'h0F;
            default: w_base = 8'hFF;
        endcase
    end

    assign wmask    = w_base << off;
    assign wdata_sh = wdata << {off, 3'b000};
    assign w_rsh    = rdata >> {off, 3'b000};

    always_comb begin
        rdata_ext = w_rsh;
        case (funct3)
            F3_B:    rdata_ext = {{56{w_rsh[7]}},  w_rsh[7:0]};
            F3_H:    rdata_ext = {{48{w_rsh[15]}}, w_rsh[15:0]};
            F3_W:    rdata_ext = {{32{w_rsh[31]}}, w_rsh[31:0]};
            F3_BU:   rdata_ext = {56'd0, w_rsh[7:0]};
            F3_HU:   rdata_ext = {48'd0, w_rsh[15:0]};
            F3_WU:   rdata_ext = {32'd0, w_rsh[31:0]};
            default: rdata_ext = w_rsh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_ctrl: single-outstanding load/store unit in front of data memory |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_misalign,
    output logic        out_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    // WAIT is entered with the counter at 0, so the last waiting cycle is TIMEOUT-1.
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    lsu_state_t  r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_load;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic        w_illegal, w_misalign, w_reject;
    logic [2:0]  w_al_f3, w_al_off;
    logic [7:0]  w_wmask;
    logic [63:0] w_wdata_sh, w_rdata_ext;

    always_comb begin
        w_illegal = 1'b1;
        if (in_load && !in_store)
            w_illegal = (in_funct3 == 3'b111);
        else if (in_store && !in_load)
            w_illegal = in_funct3[2];
    end

    assign w_misalign = is_misaligned(in_addr, in_funct3);
    assign w_reject   = w_illegal || w_misalign;
    assign in_ready   = (r_state == ST_IDLE);

    // Accept-time lanes come from the live inputs; load extraction uses the latched access.
    assign w_al_f3  = (r_state == ST_IDLE) ? in_funct3    : r_funct3;
    assign w_al_off = (r_state == ST_IDLE) ? in_addr[2:0] : r_off;

    lsu_align u_align (
        .funct3    (w_al_f3),
        .off       (w_al_off),
        .wdata     (in_wdata),
        .rdata     (mem_rdata),
        .wmask     (w_wmask),
        .wdata_sh  (w_wdata_sh),
        .rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = w_reject ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_gnt)  w_next = r_load ? ST_WAIT : ST_RESP;
            ST_WAIT: if (mem_rvalid || (r_cnt == c_tmo_last)) w_next = ST_RESP;
            ST_RESP: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= 16'd0;
            r_load       <= 1'b0;
            r_funct3     <= 3'd0;
            r_off        <= 3'd0;
            out_valid    <= 1'b0;
            out_rdata    <= 64'd0;
            out_misalign <= 1'b0;
            out_err      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 64'd0;
            mem_wmask    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_load       <= in_load;
                        r_funct3     <= in_funct3;
                        r_off        <= in_addr[2:0];
                        out_rdata    <= 64'd0;
                        out_err      <= w_illegal;
                        out_misalign <= !w_illegal && w_misalign;
                        if (w_reject) begin
                            out_valid <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= in_store;
                            mem_addr  <= {in_addr[63:3], 3'b000};
                            mem_wdata <= in_store ? w_wdata_sh : 64'd0;
                            mem_wmask <= in_store ? w_wmask : 8'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        r_cnt   <= 16'd0;
                        if (!r_load) out_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        out_rdata <= w_rdata_ext;
                        out_valid <= 1'b1;
                    end else if (r_cnt == c_tmo_last) begin
                        out_err   <= 1'b1;
                        out_rdata <= 64'd0;
                        out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store unit that sits directly upstream of the data-memory port in the NPC core. It accepts one load or store per handshake from the execute stage and issues an 8-byte-aligned request to memory. Byte lanes are generated (address alignment, write mask, write-data shift), and load data is extracted and sign/zero-extended before return. Misaligned, illegal, and timed-out accesses are reported as flags instead of being issued or left hanging.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting for `mem_rvalid` before abort (1..65535).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  execute stage presents an access.
- `in_ready`  out  1  LSU can accept; high exactly in IDLE.
- `in_load`, `in_store`  in  1  access kind; exactly one must be set.
- `in_funct3`  in  3  RISC-V width/sign code.
- `in_addr`  in  64  byte address.
- `in_wdata`  in  64  store source (rs2), right-aligned.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_rdata`  out  64  extended load data; 0 for stores and errors.
- `out_misalign`  out  1  address not aligned to access size.
- `out_err`  out  1  illegal kind/funct3, or timeout.
- `mem_req`  out  1  request to memory.
- `mem_gnt`  in  1  memory accepts the request.
- `mem_we`  out  1  write request.
- `mem_addr`  out  64  `in_addr` with bits [2:0] cleared.
- `mem_wdata`  out  64  lane-shifted store data.
- `mem_wmask`  out  8  byte enables; 0 on reads.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  64  aligned 8-byte read word.

## Operation
- Size = 1 << funct3[1:0]. Lane offset `off` = addr[2:0]. Misaligned when (addr & (size-1)) != 0.
- Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 is illegal.
- Stores: 000..011 are legal; 1xx is illegal. Both or neither of `in_load`/`in_store` set is illegal.
- Write mask = ((1<<size)-1) << off. Write data = `in_wdata` << (8*off).
- Load result = (`mem_rdata` >> 8*off), truncated to size. It is sign-extended when funct3[2]=0 and zero-extended otherwise.
- FSM states IDLE, REQ, WAIT, RESP:
  - IDLE: on `in_valid`, latch all inputs. An illegal access goes to RESP with `out_err`=1. A misaligned access goes to RESP with `out_misalign`=1. Neither case raises `mem_req`. Otherwise go to REQ.
  - REQ: `mem_req`=1 and the memory outputs are held stable until `mem_gnt`. On grant, a store goes to RESP and a load goes to WAIT with the timeout counter cleared.
  - WAIT: on `mem_rvalid`, capture the extended data and go to RESP. Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to RESP with `out_err`=1 and `out_rdata`=0; a late `mem_rvalid` is then ignored.
  - RESP: `out_valid`=1 and outputs are held until `out_ready`, then return to IDLE.
- Illegal takes priority over misaligned; only one flag is set per access.
- `rst` mid-access (any state) forces IDLE immediately. An outstanding memory transaction is abandoned.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_rdata`=0, `out_misalign`=0, `out_err`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0.
  - State IDLE, counter 0.
- All outputs are registered except `in_ready`, which is decoded from state.
- Accept in cycle 0 → `mem_req` in cycle 1.
- Store with grant in cycle 1 → `out_valid` in cycle 2.
- Load with grant in cycle 1 and `mem_rvalid` in cycle 2 → `out_valid` in cycle 3.
- Error or misaligned access → `out_valid` in cycle 1.
- `mem_rvalid` is sampled only in WAIT. Memory must return it at least one cycle after the grant.
- No new access is accepted until the RESP handshake completes (single outstanding access).
- Timeout case: `out_valid` rises in cycle 2+`TIMEOUT` when the grant is in cycle 1.

## Structure
- Package `lsu_pkg` holds:
  - the state enum;
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`);
  - function `size_of(funct3)`;
  - function `is_misaligned(addr, funct3)`.
- Sub-module `lsu_align` is purely combinational: it computes the mask, write-data shift, and read extraction/extension. It is unit-testable on its own.

## Test plan
- LB at 0x1003, `mem_rdata`=0x0000_0000_8000_0000 → `mem_addr`=0x1000, `mem_wmask`=0, `out_rdata`=0xFFFF_FFFF_FFFF_FF80.
- SH at 0x2006, `in_wdata`=0xBEEF → `mem_wmask`=0xC0, `mem_wdata`=0xBEEF_0000_0000_0000, `mem_we`=1, `out_valid` 2 cycles after accept.
- LW at 0x3002 → `out_misalign`=1, `out_valid` in cycle 1, `mem_req` never asserted.
- LWU at 0x4004 with `mem_rdata`=0xF234_5678_0000_0000 → `out_rdata`=0x0000_0000_F234_5678. Also hold `mem_gnt` low 3 cycles; `mem_req` and `mem_addr` must stay stable throughout.
- Load with `TIMEOUT`=4 and `mem_rvalid` never asserted → `out_err`=1 and `out_rdata`=0 in cycle 6. A later `mem_rvalid` has no effect.
- `rst` pulsed while in WAIT → next cycle shows IDLE, `in_ready`=1, `mem_req`=0, `out_valid`=0. Load funct3=111 → `out_err`=1, no memory request.
